// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester round-robin front end to one shared Brent-Kung adder
// Optional subtract support is enabled by defining ADDER_ARB_SUB_EN.

module BrentKung32Bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [31:0] p;
    logic [31:0] gg;
    logic [31:0] pp;

    always_comb begin
        p  = a ^ b;
        gg = a & b;
        pp = p;
        // Carry-in is folded into bit 0 so every prefix group carries it.
        gg[0] = gg[0] | (pp[0] & cin);
        for (int d = 1; d < 32; d = d * 2) begin
            for (int i = 2 * d - 1; i < 32; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end
        for (int d = 8; d > 0; d = d / 2) begin
            for (int i = 3 * d - 1; i < 32; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end
        s    = p ^ {gg[30:0], cin};
        cout = gg[31];
    end

endmodule

module adder_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_A,
    input  logic [31:0]      req0_B,
    input  logic             req0_Cin,
`ifdef ADDER_ARB_SUB_EN
    input  logic             req0_sub,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_A,
    input  logic [31:0]      req1_B,
    input  logic             req1_Cin,
`ifdef ADDER_ARB_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_S,
    output logic             rsp_Cout,
    output logic             rsp_id,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    logic        last_gnt;
    logic        slot_free;
    logic        gnt0;
    logic        gnt1;
    logic        xfer;
    logic        pop;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_cin;
    logic [31:0] sum;
    logic        sum_cout;

    assign rsp_valid = (state == FULL);
    assign slot_free = !rsp_valid || rsp_ready;
    assign pop       = rsp_valid && rsp_ready;

    // On a tie the requester that did not win last time goes first.
    assign gnt0 = req0_valid && (!req1_valid || last_gnt);
    assign gnt1 = req1_valid && (!req0_valid || !last_gnt);

    assign req0_ready = !rst && slot_free && gnt0;
    assign req1_ready = !rst && slot_free && gnt1;
    assign xfer       = req0_ready || req1_ready;

    always_comb begin
        op_a   = gnt1 ? req1_A   : req0_A;
        op_b   = gnt1 ? req1_B   : req0_B;
        op_cin = gnt1 ? req1_Cin : req0_Cin;
`ifdef ADDER_ARB_SUB_EN
        if (gnt1 ? req1_sub : req0_sub) begin
            op_b   = ~op_b;
            op_cin = 1'b1;
        end
`endif
    end

    BrentKung32Bit u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .s    (sum),
        .cout (sum_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            last_gnt <= 1'b1;
            rsp_S    <= '0;
            rsp_Cout <= 1'b0;
            rsp_id   <= 1'b0;
            ops_done <= '0;
        end else begin
            if (pop) begin
                ops_done <= ops_done + 1'b1;
            end
            if (xfer) begin
                state    <= FULL;
                rsp_S    <= sum;
                rsp_Cout <= sum_cout;
                rsp_id   <= req1_ready;
                last_gnt <= req1_ready;
            end else if (pop) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter with a transaction-level model
// Define ADDER_ARB_SUB_EN to also exercise the subtract ports.

module tb_adder_arbiter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic             req0_Cin = 1'b0, req1_Cin = 1'b0;
    logic             req0_sub = 1'b0, req1_sub = 1'b0;
    logic             rsp_valid, rsp_ready = 1'b0;
    logic [31:0]      rsp_S;
    logic             rsp_Cout, rsp_id;
    logic [CNT_W-1:0] ops_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: one result slot, round-robin pointer, pop count.
    bit          m_full;
    bit          m_last;
    int          m_cnt;
    logic [31:0] m_S;
    logic        m_C;
    bit          m_id;

    always #5 clk = ~clk;

    adder_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_Cin   (req0_Cin),
`ifdef ADDER_ARB_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_Cin   (req1_Cin),
`ifdef ADDER_ARB_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_S      (rsp_S),
        .rsp_Cout   (rsp_Cout),
        .rsp_id     (rsp_id),
        .ops_done   (ops_done)
    );

    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    function automatic bit sub_on(input logic s);
`ifdef ADDER_ARB_SUB_EN
        return s;
`else
        return 1'b0 && s;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_sub = 1'b0; req1_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_full = 0; m_last = 1; m_cnt = 0; m_S = '0; m_C = 1'b0; m_id = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rsp_valid); end
        checks++; if (rsp_S !== 32'd0 || rsp_Cout !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%0b/%0b exp 0/0/0", rsp_S, rsp_Cout, rsp_id); end
        checks++; if (ops_done !== '0) begin errors++; $display("FAIL reset_ops got %0d exp 0", ops_done); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b exp 00", req0_ready, req1_ready); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_A = 32'hFFFF0000; req0_B = 32'h0000FFFF; req0_Cin = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %0b%0b exp 10", req0_ready, req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_S !== 32'h0 || rsp_Cout !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp got %0b %h %0b %0b exp 1 00000000 1 0", rsp_valid, rsp_S, rsp_Cout, rsp_id); end
    endtask

    task automatic test_contention();
        do_reset();
        req0_valid = 1'b1; req0_A = 32'd2017701177; req0_B = 32'd1701853; req0_Cin = 1'b0;
        req1_valid = 1'b1; req1_A = 32'hFFABCEDC; req1_B = 32'hEF821EDA; req1_Cin = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL cont_first got %0b%0b exp 10", req0_ready, req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        checks++; if (rsp_S !== 32'd2019403030 || rsp_Cout !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL cont_rsp0 got %0d %0b %0b exp 2019403030 0 0", rsp_S, rsp_Cout, rsp_id); end
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL cont_second got %0b exp 1", req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        checks++; if (rsp_S !== 32'hEF2DEDB7 || rsp_Cout !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL cont_rsp1 got %h %0b %0b exp EF2DEDB7 1 1", rsp_S, rsp_Cout, rsp_id); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || ops_done !== 4'd2) begin errors++; $display("FAIL cont_drain got %0b %0d exp 0 2", rsp_valid, ops_done); end
    endtask

    task automatic test_backpressure();
        logic [32:0] e0, e1;
        do_reset();
        req0_valid = 1'b1; req0_A = 32'h12345678; req0_B = 32'h11111111; req0_Cin = 1'b0;
        req1_valid = 1'b1; req1_A = 32'h80000000; req1_B = 32'h80000001; req1_Cin = 1'b1;
        rsp_ready = 1'b0;
        e0 = ref_op(req0_A, req0_B, req0_Cin, 1'b0);
        @(posedge clk);
        @(negedge clk);
        req0_A = 32'hDEADBEEF; req0_B = 32'h00000011; req0_Cin = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d got %0b%0b exp 00", c, req0_ready, req1_ready); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || {rsp_Cout, rsp_S} !== e0 || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_hold c%0d got %0b %h %0b exp 1 %h 0", c, rsp_valid, {rsp_Cout, rsp_S}, rsp_id, e0); end
        end
        rsp_ready = 1'b1;
        e1 = ref_op(req1_A, req1_B, req1_Cin, 1'b0);
        e0 = ref_op(req0_A, req0_B, req0_Cin, 1'b0);
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_rel1 got %0b%0b exp 01", req0_ready, req1_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_id !== 1'b1 || {rsp_Cout, rsp_S} !== e1) begin errors++; $display("FAIL bp_rsp1 got %0b %h exp 1 %h", rsp_id, {rsp_Cout, rsp_S}, e1); end
        req1_A = 32'h0; req1_B = 32'h1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_rel0 got %0b%0b exp 10", req0_ready, req1_ready); end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (rsp_id !== 1'b0 || {rsp_Cout, rsp_S} !== e0 || ops_done !== 4'd2) begin errors++; $display("FAIL bp_rsp0 got %0b %h %0d exp 0 %h 2", rsp_id, {rsp_Cout, rsp_S}, ops_done, e0); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        req0_valid = 1'b1; req0_A = 32'd1; req0_B = 32'd2; req0_Cin = 1'b0;
        rsp_ready = 1'b1;
        repeat (17) @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (ops_done !== 4'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap got %0d %0b exp 1 0", ops_done, rsp_valid); end
    endtask

    task automatic test_reset_full();
        do_reset();
        req0_valid = 1'b1; req0_A = 32'd7; req0_B = 32'd9; req0_Cin = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0; req1_valid = 1'b1;
        @(posedge clk);
        #2;
        checks++; if (rsp_valid !== 1'b1 || ops_done !== 4'd1) begin errors++; $display("FAIL rf_pre got %0b %0d exp 1 1", rsp_valid, ops_done); end
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || ops_done !== 4'd0 || rsp_S !== 32'd0) begin errors++; $display("FAIL rf_async got %0b %0d %h exp 0 0 0", rsp_valid, ops_done, rsp_S); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rf_ready got %0b%0b exp 00", req0_ready, req1_ready); end
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rf_tie got %0b%0b exp 10", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

`ifdef ADDER_ARB_SUB_EN
    task automatic test_sub();
        do_reset();
        req1_valid = 1'b1; req1_sub = 1'b1; req1_A = 32'h5; req1_B = 32'h7; req1_Cin = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0; req1_sub = 1'b0;
        checks++; if (rsp_S !== 32'hFFFFFFFE || rsp_Cout !== 1'b0 || rsp_id !== 1'b1) begin errors++; $display("FAIL sub got %h %0b %0b exp FFFFFFFE 0 1", rsp_S, rsp_Cout, rsp_id); end
    endtask
`endif

    task automatic test_random();
        bit e0, e1, free, pop, held0, held1;
        logic [32:0] r;
        do_reset();
        held0 = 0; held1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!held0) begin
                req0_valid = ($urandom_range(3) != 0); req0_A = $urandom; req0_B = $urandom;
                req0_Cin = $urandom_range(1); req0_sub = $urandom_range(1);
            end
            if (!held1) begin
                req1_valid = ($urandom_range(3) != 0); req1_A = $urandom; req1_B = $urandom;
                req1_Cin = $urandom_range(1); req1_sub = $urandom_range(1);
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            free = !m_full || rsp_ready;
            e0 = free && req0_valid && (!req1_valid || m_last);
            e1 = free && req1_valid && (!req0_valid || !m_last);
            checks++; if (req0_ready !== e0 || req1_ready !== e1) begin errors++; $display("FAIL rnd_ready c%0d got %0b%0b exp %0b%0b", c, req0_ready, req1_ready, e0, e1); end
            held0 = req0_valid && !e0;
            held1 = req1_valid && !e1;
            @(posedge clk);
            pop = m_full && rsp_ready;
            if (pop) m_cnt++;
            if (e0 || e1) begin
                r = e1 ? ref_op(req1_A, req1_B, req1_Cin, sub_on(req1_sub))
                       : ref_op(req0_A, req0_B, req0_Cin, sub_on(req0_sub));
                {m_C, m_S} = r;
                m_id = e1; m_last = e1; m_full = 1;
            end else if (pop) begin
                m_full = 0;
            end
            @(negedge clk);
            checks++; if (rsp_valid !== m_full || ops_done !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_state c%0d got %0b %0d exp %0b %0d", c, rsp_valid, ops_done, m_full, CNT_W'(m_cnt)); end
            if (m_full) begin
                checks++; if (rsp_S !== m_S || rsp_Cout !== m_C || rsp_id !== m_id) begin errors++; $display("FAIL rnd_rsp c%0d got %h %0b %0b exp %h %0b %0b", c, rsp_S, rsp_Cout, rsp_id, m_S, m_C, m_id); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_counter_wrap();
        test_reset_full();
`ifdef ADDER_ARB_SUB_EN
        test_sub();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_A, req0_B  input  32 each  requester 0 operands.
REQ-007 req0_Cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_A, req1_B, req1_Cin: same as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result register holds an unconsumed result.
REQ-010 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-011 rsp_S  output  32  registered sum.
REQ-012 rsp_Cout  output  1  registered carry-out.
REQ-013 rsp_id  output  1  index of the requester that owns the result.
REQ-014 ops_done  output  CNT_W  count of results consumed (rsp_valid && rsp_ready).

Function
REQ-015 Block SHALL contain exactly one BrentKung32Bit instance, shared by both requesters; operands and Cin come from the granted requester.
REQ-016 Slot free = !rsp_valid || rsp_ready; no grant SHALL occur unless the slot is free.
REQ-017 Grant is round-robin on pointer last_gnt: if both valid, grant the requester != last_gnt; if one valid, grant it.
REQ-018 reqN_ready SHALL be combinational, high only for the granted requester; at most one ready per cycle.
REQ-019 Transfer: reqN_valid && reqN_ready; the result SHALL be captured in the result register and last_gnt updated to N on the same edge.
REQ-020 Latency: accepted at edge t -> rsp_valid high, with S/Cout/id, after edge t; sustained throughput is one operation per cycle.
REQ-021 FSM states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-022 EMPTY->FULL on a transfer; FULL->FULL on pop plus transfer (back-to-back); FULL->EMPTY on pop with no transfer; FULL holds on !rsp_ready.
REQ-023 While FULL and !rsp_ready, rsp_S, rsp_Cout and rsp_id SHALL remain stable and both ready outputs SHALL be 0.
REQ-024 Operand inputs are don't-care when their valid is low; requesters must hold operands stable while valid && !ready.
REQ-025 Arithmetic: {rsp_Cout, rsp_S} = A + B + Cin, modulo 2^33.
REQ-026 ops_done SHALL increment by 1 per pop and wrap from all-ones to 0.

Reset
REQ-027 On rst SHALL force: rsp_valid=0, rsp_S=0, rsp_Cout=0, rsp_id=0, ops_done=0, last_gnt=1 (requester 0 wins first tie), FSM=EMPTY.
REQ-028 Reset mid-operation SHALL discard any held result without producing a pop; both ready outputs SHALL be 0 while rst is high.

Configuration
REQ-029 Macro ADDER_ARB_SUB_EN defined: ports req0_sub, req1_sub (input, 1) SHALL exist; when the granted requester has sub=1, the adder SHALL receive ~B with Cin forced to 1 (result A-B, Cout=1 means no borrow).
REQ-030 Macro not defined: the sub ports SHALL be absent; behaviour SHALL be add-only per REQ-025.

Verification
REQ-031 Single request: req0 A=FFFF0000, B=0000FFFF, Cin=1, rsp_ready=1 -> next cycle rsp_S=00000000, Cout=1, id=0.
REQ-032 Contention: both valid; req0 2017701177+1701853, Cin=0; req1 FFABCEDC+EF821EDA, Cin=1 -> req0 first: S=2019403030 (decimal), Cout=0; req1 next cycle: S=EF2DEDB7, Cout=1.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles with both valid -> rsp outputs stable, both readies 0; releasing rsp_ready gives back-to-back grants alternating 1,0.
REQ-034 Counter wrap: CNT_W=4, 17 pops -> ops_done=1.
REQ-035 Reset while FULL -> rsp_valid=0 immediately, ops_done=0; after release, first tie goes to requester 0.
REQ-036 With ADDER_ARB_SUB_EN: req1 sub=1, A=00000005, B=00000007 -> S=FFFFFFFE, Cout=0.
